// File: rtl/sram_s.sv
// Simple dual-port synchronous RAM with one write port and one registered read port.
// Reads are write-first, out-of-range reads return zero, and reset clears every word.
module sram_s #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH-1:0] raddr,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata
);

  // One extra bit so that a depth of exactly 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DepthL = (ADDR_WIDTH + 1)'(DATA_DEPTH);

  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  waddr_ok;
  logic                  raddr_ok;
  logic                  wr_en;
  logic                  rd_en;

  always_comb begin
    waddr_ok = {1'b0, waddr} < DepthL;
    raddr_ok = {1'b0, raddr} < DepthL;
    wr_en    = ce && we && waddr_ok;
    rd_en    = ce && re;
  end

  always_comb begin
    rdata_d = rdata;
    if (rd_en) begin
      if (!raddr_ok) begin
        rdata_d = '0;
      end else if (wr_en && (waddr == raddr)) begin
        rdata_d = wdata;
      end else begin
        rdata_d = mem[raddr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DATA_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_s.sv
// Self-checking bench for sram_s: a full-depth instance and a 12-word instance share stimulus
// and are compared each cycle against an array-based reference model.
module tb_sram_s;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b0;
  logic       re  = 1'b0;
  logic       we  = 1'b0;
  logic [3:0] raddr = '0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;

  always #5 clk = ~clk;

  sram_s #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DATA_DEPTH(16)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .raddr (raddr),
    .re    (re),
    .rdata (rdata_a),
    .waddr (waddr),
    .we    (we),
    .wdata (wdata)
  );

  sram_s #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .DATA_DEPTH(12)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .raddr (raddr),
    .re    (re),
    .rdata (rdata_b),
    .waddr (waddr),
    .we    (we),
    .wdata (wdata)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [7:0] ref_a [16];
  logic [7:0] ref_b [12];
  logic [7:0] exp_a;
  logic [7:0] exp_b;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (ref_a[i]) ref_a[i] = 8'h00;
    foreach (ref_b[i]) ref_b[i] = 8'h00;
    exp_a = 8'h00;
    exp_b = 8'h00;
  endtask

  // Drive one cycle from just after a falling edge, then check at the next falling edge.
  task automatic cycle(input logic c, input logic r, input logic w, input logic [3:0] ra,
                       input logic [3:0] wa, input logic [7:0] wd, input string tag);
    ce = c; re = r; we = w; raddr = ra; waddr = wa; wdata = wd;
    @(posedge clk);
    if (rst) begin
      // Write-first: apply the write, then the read sees the updated array.
      if (c && w) begin
        ref_a[wa] = wd;
        if (wa < 4'd12) ref_b[wa] = wd;
      end
      if (c && r) begin
        exp_a = ref_a[ra];
        exp_b = (ra < 4'd12) ? ref_b[ra] : 8'h00;
      end
    end
    @(negedge clk);
    check({tag, "_a"}, rdata_a, exp_a);
    check({tag, "_b"}, rdata_b, exp_b);
  endtask

  task automatic async_reset(input int unsigned hold_cycles);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("rst_now_a", rdata_a, 8'h00);
    check("rst_now_b", rdata_b, 8'h00);
    for (int k = 0; k < int'(hold_cycles); k++) begin
      cycle(1'b1, 1'b1, 1'b1, 4'($urandom), 4'($urandom), 8'($urandom), "rst_hold");
    end
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    ce  = 1'b1; we = 1'b1; re = 1'b1; waddr = 4'd5; raddr = 4'd5; wdata = 8'h77;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_a", rdata_a, 8'h00);
    check("reset_b", rdata_b, 8'h00);
    rst = 1'b1;

    cycle(1'b1, 1'b1, 1'b0, 4'd5, 4'd0, 8'h00, "first_read");

    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 4'd0, 4'(i), 8'(i), "fill");
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'(i), 4'd0, 8'h00, "fill_read");
    end

    cycle(1'b1, 1'b1, 1'b1, 4'd3, 4'd3, 8'hA5, "write_first");
    cycle(1'b1, 1'b1, 1'b1, 4'd3, 4'd14, 8'h5A, "diff_addr");
    cycle(1'b1, 1'b1, 1'b0, 4'd14, 4'd0, 8'h00, "oor_read");
    cycle(1'b1, 1'b1, 1'b0, 4'd3, 4'd0, 8'h00, "reread3");

    cycle(1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 8'h11, "wr7");
    cycle(1'b1, 1'b1, 1'b0, 4'd4, 4'd0, 8'h00, "rd4");
    cycle(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 8'hFF, "ce_off");
    cycle(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 8'hFF, "ce_off2");
    cycle(1'b1, 1'b1, 1'b0, 4'd7, 4'd0, 8'h00, "rd7");

    cycle(1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 8'h00, "rd2");
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 4'd9, 4'd0, 8'h00, "hold");
    end

    async_reset(2);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'(i), 4'd0, 8'h00, "post_rst");
    end

    for (int n = 0; n < 400; n++) begin
      logic [3:0] ra;
      logic [3:0] wa;
      ra = 4'($urandom);
      wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        async_reset($urandom_range(1, 3));
      end else begin
        cycle($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), ra, wa, 8'($urandom),
              "rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
